tile_writeback: RTL and testbench

TILE_WRITEBACK -- requirements
Module: tile_writeback

---
 rtl/tile_writeback.sv | 140 ++++++++++++++
 tb/tb_tile_writeback.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_writeback.sv
// Streams one 32x32 RGB565 tile from tile memory to a linear framebuffer over an
// Avalon-MM write master, buffering reads in a 4-entry FIFO to absorb slave stalls.
module tile_writeback #(
    parameter logic [31:0] FB_BASE   = 32'h0000_0000,
    parameter int unsigned FB_STRIDE = 1280
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  tile_x,
    input  logic [5:0]  tile_y,
    input  logic        render_done,
    output logic [9:0]  tile_addr,
    input  logic [15:0] tile_data,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [15:0] avm_writedata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, WAIT_TILE, STREAM, FINISH} state_t;

    localparam logic [31:0] ROW_PITCH  = 32'(FB_STRIDE);
    localparam logic [31:0] TILE_PITCH = 32'(FB_STRIDE * 32);

    state_t      state_q;
    logic [5:0]  tile_x_q, tile_y_q;
    logic [31:0] row_base_q, addr_q;
    logic [4:0]  col_q;
    logic [10:0] rd_cnt_q, wr_cnt_q;
    logic        inflight_q;
    logic [15:0] fifo_mem_q [4];
    logic [1:0]  fifo_wr_q, fifo_rd_q;
    logic [2:0]  fifo_cnt_q;
    logic [9:0]  tile_addr_q;
    logic        busy_q, done_q;

    logic [31:0] tile_base_d, row_base_d;
    logic        issue, push, pop;

    // Only the per-tile origin uses a multiply; it settles while waiting for the renderer.
    assign tile_base_d = FB_BASE + ({26'd0, tile_y_q} * TILE_PITCH) + {20'd0, tile_x_q, 6'd0};
    assign row_base_d  = row_base_q + ROW_PITCH;

    // Occupancy counts reads still in flight so a stalled slave can never overflow the FIFO.
    assign issue = (state_q == STREAM) && !rd_cnt_q[10] &&
                   ((fifo_cnt_q + 3'(inflight_q)) < 3'd4);
    assign push  = inflight_q;
    assign pop   = avm_write && !avm_waitrequest;

    assign avm_write     = (state_q == STREAM) && (fifo_cnt_q != 3'd0);
    assign avm_writedata = (fifo_cnt_q != 3'd0) ? fifo_mem_q[fifo_rd_q] : 16'd0;
    assign avm_address   = addr_q;
    assign tile_addr     = issue ? rd_cnt_q[9:0] : tile_addr_q;
    assign busy          = busy_q;
    assign done          = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tile_x_q    <= 6'd0;
            tile_y_q    <= 6'd0;
            row_base_q  <= 32'd0;
            addr_q      <= 32'd0;
            col_q       <= 5'd0;
            rd_cnt_q    <= 11'd0;
            wr_cnt_q    <= 11'd0;
            inflight_q  <= 1'b0;
            fifo_wr_q   <= 2'd0;
            fifo_rd_q   <= 2'd0;
            fifo_cnt_q  <= 3'd0;
            tile_addr_q <= 10'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tile_addr_q <= 10'd0;
                    inflight_q  <= 1'b0;
                    fifo_wr_q   <= 2'd0;
                    fifo_rd_q   <= 2'd0;
                    fifo_cnt_q  <= 3'd0;
                    if (start) begin
                        tile_x_q <= tile_x;
                        tile_y_q <= tile_y;
                        busy_q   <= 1'b1;
                        state_q  <= WAIT_TILE;
                    end
                end
                WAIT_TILE: begin
                    row_base_q <= tile_base_d;
                    addr_q     <= tile_base_d;
                    col_q      <= 5'd0;
                    rd_cnt_q   <= 11'd0;
                    wr_cnt_q   <= 11'd0;
                    if (render_done) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    inflight_q <= issue;
                    if (issue) begin
                        tile_addr_q <= rd_cnt_q[9:0];
                        rd_cnt_q    <= rd_cnt_q + 11'd1;
                    end
                    if (push) begin
                        fifo_mem_q[fifo_wr_q] <= tile_data;
                        fifo_wr_q             <= fifo_wr_q + 2'd1;
                    end
                    fifo_cnt_q <= fifo_cnt_q + 3'(push) - 3'(pop);
                    if (pop) begin
                        fifo_rd_q <= fifo_rd_q + 2'd1;
                        wr_cnt_q  <= wr_cnt_q + 11'd1;
                        if (col_q == 5'd31) begin
                            row_base_q <= row_base_d;
                            addr_q     <= row_base_d;
                            col_q      <= 5'd0;
                        end else begin
                            addr_q <= addr_q + 32'd2;
                            col_q  <= col_q + 5'd1;
                        end
                        if (wr_cnt_q == 11'd1023) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_writeback.sv
// Directed bench for tile_writeback: two instances (base 0 and base 0x1000_0000)
// share stimulus; a negedge monitor captures completed writes for later checking.
module tb_tile_writeback;

    logic        clk = 1'b0;
    logic        reset, start, render_done, wreq;
    logic [5:0]  tile_x, tile_y;

    logic [9:0]  tile_addr_a, tile_addr_b;
    logic [15:0] tile_data_a, tile_data_b;
    logic [31:0] a_addr, b_addr;
    logic        a_write, b_write, busy_a, busy_b, done_a, done_b;
    logic [15:0] a_data, b_data;

    logic [15:0] tmem [1024];
    logic [31:0] cap_addr_a [1024];
    logic [15:0] cap_data_a [1024];
    logic [31:0] cap_addr_b [1024];

    int tests = 0, fails = 0;
    int cyc = 0, wcnt_a = 0, wcnt_b = 0, done_cnt_a = 0;
    int first_cyc = 0, last_cyc = 0, start_edge = 0;
    int stall_viol = 0, occ_viol = 0, max_occ = 0;
    logic        stall_prev = 1'b0, reset_prev = 1'b0;
    logic [31:0] p_addr = 32'd0;
    logic [15:0] p_data = 16'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) tile_data_a <= tmem[tile_addr_a];
    always @(posedge clk) tile_data_b <= tmem[tile_addr_b];

    tile_writeback #(.FB_BASE(32'h0000_0000), .FB_STRIDE(1280)) dut_a (
        .clk(clk), .reset(reset), .start(start), .tile_x(tile_x), .tile_y(tile_y),
        .render_done(render_done), .tile_addr(tile_addr_a), .tile_data(tile_data_a),
        .avm_address(a_addr), .avm_write(a_write), .avm_writedata(a_data),
        .avm_waitrequest(wreq), .busy(busy_a), .done(done_a)
    );

    tile_writeback #(.FB_BASE(32'h1000_0000), .FB_STRIDE(1280)) dut_b (
        .clk(clk), .reset(reset), .start(start), .tile_x(tile_x), .tile_y(tile_y),
        .render_done(render_done), .tile_addr(tile_addr_b), .tile_data(tile_data_b),
        .avm_address(b_addr), .avm_write(b_write), .avm_writedata(b_data),
        .avm_waitrequest(wreq), .busy(busy_b), .done(done_b)
    );

    // Write capture, stall-stability and FIFO occupancy monitor
    always @(negedge clk) begin
        if (a_write && !wreq) begin
            if (wcnt_a < 1024) begin
                cap_addr_a[wcnt_a] = a_addr;
                cap_data_a[wcnt_a] = a_data;
            end
            if (wcnt_a == 0) first_cyc = cyc;
            last_cyc = cyc;
            wcnt_a++;
        end
        if (b_write && !wreq) begin
            if (wcnt_b < 1024) cap_addr_b[wcnt_b] = b_addr;
            wcnt_b++;
        end
        if (done_a) begin
            done_cnt_a++;
            if (!busy_a) stall_viol++;
        end
        if (stall_prev && !reset_prev) begin
            if (!(a_write && a_addr == p_addr && a_data == p_data)) stall_viol++;
        end
        stall_prev = a_write && wreq;
        reset_prev = reset;
        p_addr = a_addr;
        p_data = a_data;
        if (int'(dut_a.fifo_cnt_q) > max_occ) max_occ = int'(dut_a.fifo_cnt_q);
        if (dut_a.fifo_cnt_q > 3'd4) occ_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int tx,
                                              input int ty, input int i);
        return base + 32'((ty * 32 + i / 32) * 1280 + (tx * 32 + i % 32) * 2);
    endfunction

    task automatic start_tile(input int tx, input int ty);
        @(posedge clk); #1;
        wcnt_a = 0; wcnt_b = 0; done_cnt_a = 0;
        start  = 1'b1;
        tile_x = 6'(tx);
        tile_y = 6'(ty);
        start_edge = cyc + 1;
    endtask

    // Runs until the done pulse has passed; optional random stalls, a duplicate
    // start mid-stream, and a start pulse in the FINISH cycle.
    task automatic run_tile(input int rnd, input int dup_at, input int fin_start);
        int ok = 0;
        int dup_sent = 0;
        for (int n = 0; n < 20000; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            wreq  = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (dup_at >= 0 && dup_sent == 0 && wcnt_a >= dup_at) begin
                start = 1'b1; tile_x = 6'd7; tile_y = 6'd9; dup_sent = 1;
            end
            if (done_a && fin_start != 0) start = 1'b1;
            if (done_cnt_a > 0 && !done_a) begin
                ok = 1;
                break;
            end
        end
        start = 1'b0;
        wreq  = 1'b0;
        check("run_timeout", 32'(ok), 32'd1);
    endtask

    task automatic verify_tile(input int tx, input int ty);
        int bad_d = 0, bad_a = 0, bad_b = 0;
        for (int i = 0; i < 1024; i++) begin
            if (cap_data_a[i] !== tmem[i]) bad_d++;
            if (cap_addr_a[i] !== exp_addr(32'h0000_0000, tx, ty, i)) bad_a++;
            if (cap_addr_b[i] !== exp_addr(32'h1000_0000, tx, ty, i)) bad_b++;
        end
        @(negedge clk);
        check("wr_count", 32'(wcnt_a), 32'd1024);
        check("data_order", 32'(bad_d), 32'd0);
        check("addr_a", 32'(bad_a), 32'd0);
        check("addr_b", 32'(bad_b), 32'd0);
        check("done_once", 32'(done_cnt_a), 32'd1);
        check("busy_after", 32'(busy_a), 32'd0);
        $display("[TB] tile (%0d,%0d): %0d writes, first 0x%08h last 0x%08h", tx, ty,
                 wcnt_a, cap_addr_a[0], cap_addr_a[1023]);
    endtask

    initial begin
        int viol;
        reset = 1'b1; start = 1'b0; render_done = 1'b1; wreq = 1'b0;
        tile_x = 6'd0; tile_y = 6'd0;
        for (int i = 0; i < 1024; i++) tmem[i] = 16'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_write", 32'(a_write), 32'd0);
        check("rst_addr", a_addr, 32'd0);
        check("rst_data", 32'(a_data), 32'd0);
        check("rst_tile_addr", 32'(tile_addr_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Tile (0,0), no stalls: back-to-back writes after fixed latency
        start_tile(0, 0);
        run_tile(0, -1, 0);
        verify_tile(0, 0);
        check("first_latency", 32'(first_cyc - start_edge), 32'd3);
        check("back_to_back", 32'(last_cyc - first_cyc), 32'd1023);
        check("addr_col31", cap_addr_a[31], 32'd62);
        check("addr_row1", cap_addr_a[32], 32'd1280);
        check("data_last", 32'(cap_data_a[1023]), 32'd1023);

        // Tile (19,14) with random stalls and a fresh data pattern
        for (int i = 0; i < 1024; i++) tmem[i] = 16'hFFFF - 16'(i);
        start_tile(19, 14);
        run_tile(1, -1, 0);
        verify_tile(19, 14);
        check("b_first_addr", cap_addr_b[0], 32'h1008_C4C0);
        check("b_last_addr", cap_addr_b[1023], 32'h1008_C4C0 + 32'd39742);
        check("stall_stable", 32'(stall_viol), 32'd0);
        check("fifo_bound", 32'(occ_viol), 32'd0);
        check("fifo_filled", 32'(max_occ >= 2), 32'd1);

        // render_done low for 20 cycles: nothing moves, busy held
        for (int i = 0; i < 1024; i++) tmem[i] = 16'(i * 37 + 5);
        render_done = 1'b0;
        start_tile(1, 2);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (!busy_a || a_write || tile_addr_a != 10'd0) viol++;
        end
        check("wait_render", 32'(viol), 32'd0);
        render_done = 1'b1;
        run_tile(0, 300, 1);
        verify_tile(1, 2);
        repeat (2) @(negedge clk);
        check("finish_start_ignored", 32'(busy_a), 32'd0);

        // Reset during a stalled write at write 500, then a full tile again
        start_tile(3, 5);
        viol = 1;
        for (int n = 0; n < 5000; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (wcnt_a >= 500) begin
                viol = 0;
                break;
            end
        end
        check("reach_500", 32'(viol), 32'd0);
        wreq = 1'b1;
        @(negedge clk);
        check("stalled_write", 32'(a_write), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_write", 32'(a_write), 32'd0);
        check("rst_mid_busy", 32'(busy_a), 32'd0);
        check("rst_mid_tile_addr", 32'(tile_addr_a), 32'd0);
        wreq = 1'b0;
        start_tile(0, 0);
        run_tile(0, -1, 0);
        verify_tile(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
